// File: rtl/piso_serializer_ctrl_pkg.sv
// Shared types for the PISO serializer controller.
// Holds the FSM state encoding and a counter-width helper.
package piso_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_serializer_ctrl_if.sv
// Producer and line-side bundle of the PISO serializer controller.
// master: drives in_valid/in_data/en; slave: returns ready, serial bit and flags.
interface piso_serializer_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             en;
    logic             sout;
    logic             sout_valid;
    logic             sout_first;
    logic             sout_last;
    logic             busy;

    modport master (
        output in_valid,
        output in_data,
        output en,
        input  in_ready,
        input  sout,
        input  sout_valid,
        input  sout_first,
        input  sout_last,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  en,
        output in_ready,
        output sout,
        output sout_valid,
        output sout_first,
        output sout_last,
        output busy
    );

endinterface

// File: rtl/piso_serializer_ctrl_sr.sv
// Right-shift register feeding the serial line, zero filled at the MSB.
// Ports: clk, reset (sync), load (wins), ena (shift), data in, q out.
module piso_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             ena,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else if (load) begin
            q_q <= data;
        end else if (ena) begin
            q_q <= {1'b0, q_q[WIDTH-1:1]};
        end
    end

    assign q = q_q;

endmodule

// File: rtl/piso_serializer_ctrl.sv
// Serializes parallel words LSB first through a one-entry holding buffer.
// Ports: clk, reset (sync, active high), bus (slave side), see interface.
module piso_serializer_ctrl
    import piso_ctrl_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    piso_serializer_ctrl_if.slave bus
);

    localparam int BW = cnt_w(WIDTH);
    localparam int GW = cnt_w(GAP_CYCLES + 1);
    localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GLAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    state_e           state_q, state_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;

    logic             load;
    logic             shift;
    logic             accept;
    logic             in_ready;
    logic [WIDTH-1:0] sr_q;
    logic             unused_sr;

    assign accept    = bus.in_valid & in_ready;
    assign unused_sr = ^sr_q[WIDTH-1:1];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bcnt_q      <= '0;
            gcnt_q      <= '0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            gcnt_q      <= gcnt_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
        end
    end

    // Holding buffer: a load drains it, an accept refills it.
    // in_ready is low while full, so both never land on one entry.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = bus.in_data;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        gcnt_d  = gcnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    bcnt_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.en) begin
                    shift = 1'b1;
                    if (bcnt_q == BLAST) begin
                        bcnt_d = '0;
                        if (HAS_GAP) begin
                            gcnt_d  = '0;
                            state_d = GAP;
                        end else if (hold_full_q) begin
                            // Next word follows with no bubble;
                            // the load overrides the final shift.
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (bus.en) begin
                    if (gcnt_q == GLAST) begin
                        gcnt_d = '0;
                        if (hold_full_q) begin
                            load    = 1'b1;
                            bcnt_d  = '0;
                            state_d = SHIFT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        gcnt_d = gcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        in_ready       = ~hold_full_q & ~reset;
        bus.in_ready   = in_ready;
        bus.sout       = sr_q[0];
        bus.sout_valid = (state_q == SHIFT) & bus.en;
        bus.sout_first = (state_q == SHIFT) & bus.en
                       & (bcnt_q == '0);
        bus.sout_last  = (state_q == SHIFT) & bus.en
                       & (bcnt_q == BLAST);
        bus.busy       = (state_q != IDLE) | hold_full_q;
    end

    piso_shift_reg #(
        .WIDTH(WIDTH)
    ) sr (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .ena  (shift),
        .data (hold_data_q),
        .q    (sr_q)
    );

endmodule

// File: doc/piso_serializer_ctrl.md
Name: piso_serializer_ctrl

Overview:
Controller that sequences a right-shift PISO register to serialize a stream of parallel words, LSB first.
Accepts words on a valid/ready interface into a one-entry holding buffer, so consecutive words stream with no bubble.
Decides each cycle whether to load or shift, counts bits, and inserts an optional idle gap between words.
Sits between a parallel producer and a serial line driver; en lets the line side stall the bit stream.

Parameters:
WIDTH, 4, bits per word; must be >= 2.
GAP_CYCLES, 0, idle cycles inserted after each word's last bit; 0 means back-to-back.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous active-high reset.
in_valid  input  1  producer presents in_data.
in_ready  output  1  holding buffer can accept a word.
in_data  input  WIDTH  parallel word to serialize.
en  input  1  line-side advance enable; 0 stalls shifting and gap counting.
sout  output  1  serial bit, equal to sr[0].
sout_valid  output  1  sout carries a bit this cycle.
sout_first  output  1  bit 0 of a word is on sout this cycle.
sout_last  output  1  bit WIDTH-1 of a word is on sout this cycle.
busy  output  1  word in flight or buffered.

Behaviour:
- Reset (sync, posedge clk with reset=1): state=IDLE, sr=0, bcnt=0, gcnt=0, hold_full=0. While reset is high: in_ready=0 and any in_valid is ignored. After reset: sout=0, sout_valid/first/last=0, busy=0, in_ready=1.
- Reset mid-word or mid-gap aborts the word and discards any held word; nothing partial appears after reset.
- Handshake: in_ready = ~hold_full & ~reset. A word is accepted when in_valid & in_ready, captured into hold_data, and hold_full=1 next cycle.
- in_valid may drop without being accepted; in_data is sampled only on accept.
- Drain: hold is emptied when it is loaded into sr. If hold drains and a new word is accepted in the same cycle, hold takes the new word and hold_full stays 1.
- Load priority: a load always wins over a shift in the same cycle. Load sets sr=hold_data and bcnt=0.
- States:
  IDLE: if hold_full, load and go to SHIFT; else stay.
  SHIFT: sout_valid=en.
    - en=1: sr shifts right with 0 into the MSB, and bcnt increments.
    - At bcnt==WIDTH-1 with en=1 (last bit):
      - If GAP_CYCLES>0: go to GAP with gcnt=0.
      - Else if hold_full: load and stay in SHIFT (no bubble).
      - Else: go to IDLE.
    - en=0: sr, bcnt and sout hold.
  GAP: sout_valid=0. gcnt increments only when en=1. At gcnt==GAP_CYCLES-1 with en=1:
    - If hold_full: load and go to SHIFT.
    - Else: go to IDLE.
- Latency: a word accepted in cycle N is in hold at N+1, loaded at the end of N+1, and its bit 0 is on sout in cycle N+2 (en=1, idle controller).
- sout_first = (state==SHIFT) & (bcnt==0) & en.
- sout_last = (state==SHIFT) & (bcnt==WIDTH-1) & en.
- busy = (state!=IDLE) | hold_full.
- Widths: bcnt uses $clog2(WIDTH) bits. gcnt uses $clog2(GAP_CYCLES+1) bits, minimum 1 bit. No counter wraps past its terminal value.

Decomposition:
- Package piso_ctrl_pkg: state enum (IDLE, SHIFT, GAP), encoded in 2 bits.
- Sub-module piso_shift_reg (clk, reset, load, ena, data[WIDTH-1:0], q[WIDTH-1:0]). It is a right-shift register with sync reset; load has priority over ena. The controller instantiates it as sr, with sout = q[0].
- Holding buffer, counters and FSM stay in the top module.

Test Plan:
- Single word (WIDTH=4, en=1): accept 4'b1011 at cycle 0 -> cycles 2..5 show sout=1,1,0,1 with sout_valid=1; sout_first at cycle 2, sout_last at cycle 5; busy=0 from cycle 6.
- Back-to-back, GAP_CYCLES=0: hold in_valid with 4'hA then 4'h5 -> 8 contiguous valid bits 0,1,0,1,1,0,1,0; in_ready=0 while hold_full; no sout_valid bubble between the words.
- Stall: word 4'b0110, en=0 for 3 cycles when bcnt==2 -> sout_valid=0 and sout held at 1 for those cycles; bit 2 and then bit 3 resume once en=1; sout_last fires exactly once.
- Gap, GAP_CYCLES=2: words 4'hF then 4'h0 back-to-back -> 4 valid 1s, 2 cycles with sout_valid=0, then 4 valid 0s.
- Reset mid-word: reset for 1 cycle after bit 1, with a second word held -> next cycle sout_valid=0, busy=0, in_ready=1; the held word never appears.
- Accept during reset: in_valid=1 while reset=1 -> in_ready=0; after release busy stays 0 and no bits are emitted.
